// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller between a CPU load/store
// port, an external Status_Tag/Data RAM pair (1-cycle read latency) and a line-wide memory port.
module cache_ctrl #(
   parameter int tag_len    = 13,
   parameter int index_len  = 10,
   parameter int offset_len = 4,
   localparam int LINE   = 32 * (2 ** (offset_len - 2)),
   localparam int ADDR_W = tag_len + index_len + offset_len,
   localparam int WSEL_W = offset_len - 2
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         req_valid,
   input  logic                         req_we,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic [31:0]                  req_wdata,
   output logic                         req_ready,
   output logic                         resp_valid,
   output logic [31:0]                  resp_rdata,
   output logic [index_len-1:0]         ram_addr,
   output logic                         ram_tag_we,
   output logic                         ram_data_we,
   output logic [tag_len-1:0]           ram_tag_in,
   output logic [2:0]                   ram_status_in,
   input  logic [tag_len-1:0]           ram_tag_out,
   input  logic [2:0]                   ram_status_out,
   output logic [LINE-1:0]              ram_data_in,
   input  logic [LINE-1:0]              ram_data_out,
   output logic                         mem_req_valid,
   output logic                         mem_req_we,
   output logic [tag_len+index_len-1:0] mem_req_addr,
   output logic [LINE-1:0]              mem_wdata,
   input  logic                         mem_req_ready,
   input  logic                         mem_resp_valid,
   input  logic [LINE-1:0]              mem_rdata
);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_LOOKUP, S_WB, S_FILL_REQ, S_FILL_WAIT, S_REFILL
   } state_t;

   localparam logic [index_len-1:0] IDX_ONE = 1;

   state_t                r_state;
   state_t                w_next;
   logic [index_len-1:0]  r_init_cnt;
   logic [ADDR_W-3:0]     r_addr;
   logic                  r_we;
   logic [31:0]           r_wdata;
   logic [tag_len-1:0]    r_vic_tag;
   logic [LINE-1:0]       r_vic_data;
   logic [LINE-1:0]       r_fill;
   logic                  r_resp_valid;
   logic [31:0]           r_resp_rdata;

   logic [index_len-1:0]  w_req_idx;
   logic [index_len-1:0]  w_idx;
   logic [tag_len-1:0]    w_tag;
   logic [WSEL_W-1:0]     w_wsel;
   logic                  w_hit;
   logic [31:0]           w_hit_word;
   logic [31:0]           w_fill_word;
   logic [LINE-1:0]       w_hit_line;
   logic [LINE-1:0]       w_fill_line;
   logic                  w_unused;

   // Byte-within-word bits never reach the cache.
   assign w_unused    = ^req_addr[1:0];
   assign w_req_idx   = req_addr[offset_len +: index_len];
   assign w_idx       = r_addr[WSEL_W +: index_len];
   assign w_tag       = r_addr[WSEL_W + index_len +: tag_len];
   assign w_wsel      = r_addr[0 +: WSEL_W];
   assign w_hit       = ram_status_out[0] && (ram_tag_out == w_tag);
   assign w_hit_word  = ram_data_out[32 * w_wsel +: 32];
   assign w_fill_word = r_fill[32 * w_wsel +: 32];
   assign resp_valid  = r_resp_valid;
   assign resp_rdata  = r_resp_rdata;

   always_comb begin
      w_hit_line = ram_data_out;
      w_hit_line[32 * w_wsel +: 32] = r_wdata;
      w_fill_line = r_fill;
      if (r_we) w_fill_line[32 * w_wsel +: 32] = r_wdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_INIT;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_INIT:      if (r_init_cnt == '1) w_next = S_IDLE;
         S_IDLE:      if (req_valid) w_next = S_LOOKUP;
         S_LOOKUP: begin
            if (w_hit)                          w_next = S_IDLE;
            else if (ram_status_out == 3'b011)  w_next = S_WB;
            else                                w_next = S_FILL_REQ;
         end
         S_WB:        if (mem_req_ready) w_next = S_FILL_REQ;
         S_FILL_REQ:  if (mem_req_ready) w_next = S_FILL_WAIT;
         S_FILL_WAIT: if (mem_resp_valid) w_next = S_REFILL;
         S_REFILL:    w_next = S_IDLE;
         default:     w_next = S_INIT;
      endcase
   end

   always_comb begin
      req_ready     = 1'b0;
      ram_addr      = w_idx;
      ram_tag_we    = 1'b0;
      ram_data_we   = 1'b0;
      ram_tag_in    = '0;
      ram_status_in = 3'b000;
      ram_data_in   = '0;
      mem_req_valid = 1'b0;
      mem_req_we    = 1'b0;
      mem_req_addr  = '0;
      mem_wdata     = '0;
      unique case (r_state)
         // Gated by rstn so the clearing writes stop the moment reset asserts.
         S_INIT: begin
            ram_addr   = r_init_cnt;
            ram_tag_we = rstn;
         end
         S_IDLE: begin
            req_ready = 1'b1;
            ram_addr  = w_req_idx;
         end
         S_LOOKUP: begin
            if (w_hit && r_we) begin
               ram_tag_we    = 1'b1;
               ram_data_we   = 1'b1;
               ram_tag_in    = w_tag;
               ram_status_in = 3'b011;
               ram_data_in   = w_hit_line;
            end
         end
         S_WB: begin
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = {r_vic_tag, w_idx};
            mem_wdata     = r_vic_data;
         end
         S_FILL_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {w_tag, w_idx};
         end
         S_REFILL: begin
            ram_tag_we    = 1'b1;
            ram_data_we   = 1'b1;
            ram_tag_in    = w_tag;
            ram_status_in = {1'b0, r_we, 1'b1};
            ram_data_in   = w_fill_line;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_init_cnt   <= '0;
         r_addr       <= '0;
         r_we         <= 1'b0;
         r_wdata      <= '0;
         r_vic_tag    <= '0;
         r_vic_data   <= '0;
         r_fill       <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         unique case (r_state)
            S_INIT: r_init_cnt <= r_init_cnt + IDX_ONE;
            S_IDLE: begin
               if (req_valid) begin
                  r_addr  <= req_addr[ADDR_W-1:2];
                  r_we    <= req_we;
                  r_wdata <= req_wdata;
               end
            end
            S_LOOKUP: begin
               r_vic_tag  <= ram_tag_out;
               r_vic_data <= ram_data_out;
               if (w_hit) begin
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= w_hit_word;
               end
            end
            S_FILL_WAIT: if (mem_resp_valid) r_fill <= mem_rdata;
            S_REFILL: begin
               r_resp_valid <= 1'b1;
               r_resp_rdata <= w_fill_word;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: models the tag/data RAMs and main memory, and checks every response
// against a flat word-addressed view of memory (the cache must be transparent).
module tb_cache_ctrl;
   localparam int TAG_W = 13;
   localparam int IDX_W = 10;
   localparam int OFF_W = 4;
   localparam int LINE  = 128;
   localparam int AW    = 27;
   localparam int LA_W  = 23;

   logic              clk = 1'b0;
   logic              rstn;
   logic              req_valid, req_we, req_ready, resp_valid;
   logic [AW-1:0]     req_addr;
   logic [31:0]       req_wdata, resp_rdata;
   logic [IDX_W-1:0]  ram_addr;
   logic              ram_tag_we, ram_data_we;
   logic [TAG_W-1:0]  ram_tag_in, ram_tag_out;
   logic [2:0]        ram_status_in, ram_status_out;
   logic [LINE-1:0]   ram_data_in, ram_data_out;
   logic              mem_req_valid, mem_req_we, mem_req_ready, mem_resp_valid;
   logic [LA_W-1:0]   mem_req_addr;
   logic [LINE-1:0]   mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   cache_ctrl #(.tag_len(TAG_W), .index_len(IDX_W), .offset_len(OFF_W)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .ram_addr(ram_addr), .ram_tag_we(ram_tag_we), .ram_data_we(ram_data_we),
      .ram_tag_in(ram_tag_in), .ram_status_in(ram_status_in), .ram_tag_out(ram_tag_out),
      .ram_status_out(ram_status_out), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
      .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
      .mem_wdata(mem_wdata), .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
      .mem_rdata(mem_rdata)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic ok, input logic [127:0] act,
                        input logic [127:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic finish_run();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   endtask

   // Initial main-memory image; line 0x00123 holds words {4,3,2,1}.
   function automatic logic [127:0] init_line(input logic [LA_W-1:0] la);
      logic [127:0] l;
      if (la == 23'h00123) return {32'd4, 32'd3, 32'd2, 32'd1};
      for (int w = 0; w < 4; w++) l[32*w +: 32] = {la, 2'(w), 7'h5a};
      return l;
   endfunction

   // Reference model: memory as seen by the CPU, one word per key.
   logic [31:0] ref_mem [logic [24:0]];
   function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
      logic [127:0] l;
      if (ref_mem.exists(a[26:2])) return ref_mem[a[26:2]];
      l = init_line(a[26:4]);
      return l[32*a[3:2] +: 32];
   endfunction

   // Main memory behind the cache.
   logic [127:0] main_mem [logic [LA_W-1:0]];
   function automatic logic [127:0] mem_line(input logic [LA_W-1:0] la);
      if (main_mem.exists(la)) return main_mem[la];
      return init_line(la);
   endfunction

   // Status/tag and data RAMs with 1-cycle read latency.
   logic [TAG_W-1:0] tag_mem    [1024];
   logic [2:0]       status_mem [1024];
   logic [127:0]     data_mem   [1024];
   logic             fill_junk = 1'b0;
   always @(posedge clk) begin
      if (fill_junk) begin
         for (int i = 0; i < 1024; i++) begin
            tag_mem[i]    <= TAG_W'($urandom);
            status_mem[i] <= 3'($urandom);
            data_mem[i]   <= {$urandom, $urandom, $urandom, $urandom};
         end
      end else begin
         if (ram_tag_we) begin
            tag_mem[ram_addr]    <= ram_tag_in;
            status_mem[ram_addr] <= ram_status_in;
         end
         if (ram_data_we) data_mem[ram_addr] <= ram_data_in;
      end
      ram_tag_out    <= tag_mem[ram_addr];
      ram_status_out <= status_mem[ram_addr];
      ram_data_out   <= data_mem[ram_addr];
   end

   // Memory responder: configurable ready hold-off, response delay and stray response pulses.
   int              cfg_hold  = 0;
   int              cfg_delay = 0;
   bit              cfg_junk  = 1'b0;
   logic            log_we    [$];
   logic [LA_W-1:0] log_addr  [$];
   logic [127:0]    log_wdata [$];
   logic            pend, held, waiting;
   int              pend_cnt, hold_left;
   logic [LA_W-1:0] pend_la, held_addr;
   logic            held_we;
   logic [127:0]    held_wdata;

   initial begin
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
      pend = 1'b0; held = 1'b0; waiting = 1'b0; pend_cnt = 0; hold_left = 0;
      forever begin
         @(negedge clk);
         mem_resp_valid = 1'b0;
         if (!rstn) begin
            pend = 1'b0; held = 1'b0; waiting = 1'b0; mem_req_ready = 1'b0;
            continue;
         end
         if (held)
            check("mem_req_stable", mem_req_valid && mem_req_we == held_we &&
                  mem_req_addr == held_addr && mem_wdata == held_wdata,
                  {mem_req_valid, mem_req_we, mem_req_addr}, {1'b1, held_we, held_addr});
         if (pend) begin
            if (pend_cnt == 0) begin
               mem_resp_valid = 1'b1; mem_rdata = mem_line(pend_la); pend = 1'b0;
            end else pend_cnt--;
         end else if (cfg_junk && $urandom_range(0, 5) == 0) begin
            mem_resp_valid = 1'b1; mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         end
         mem_req_ready = 1'b0;
         if (mem_req_valid) begin
            if (!waiting) begin
               waiting = 1'b1;
               hold_left = (cfg_hold < 0) ? int'($urandom_range(0, 3)) : cfg_hold;
            end
            if (hold_left > 0) hold_left--;
            else begin
               mem_req_ready = 1'b1; waiting = 1'b0;
               log_we.push_back(mem_req_we);
               log_addr.push_back(mem_req_addr);
               log_wdata.push_back(mem_wdata);
               if (mem_req_we) main_mem[mem_req_addr] = mem_wdata;
               else begin
                  pend = 1'b1; pend_la = mem_req_addr;
                  pend_cnt = (cfg_delay < 0) ? int'($urandom_range(0, 4)) : cfg_delay;
               end
            end
         end
         held = mem_req_valid && !mem_req_ready;
         held_we = mem_req_we; held_addr = mem_req_addr; held_wdata = mem_wdata;
      end
   end

   // Scoreboard: {is_load, data} per accepted request, popped on each response.
   logic [32:0] exp_q [$];
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (rstn && resp_valid) begin
            check("resp_expected", exp_q.size() > 0, resp_rdata, 0);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               if (e[32]) check("load_data", resp_rdata == e[31:0], resp_rdata, e[31:0]);
            end
         end
      end
   end

   task automatic issue(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
      int guard = 0;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      while (!req_ready) begin
         @(negedge clk);
         guard++;
         if (guard > 500) begin
            check("req_accept_timeout", 1'b0, guard, 500);
            finish_run();
         end
      end
      @(posedge clk);
      if (we) begin
         exp_q.push_back({1'b0, d});
         ref_mem[a[26:2]] = d;
      end else exp_q.push_back({1'b1, ref_read(a)});
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic issue_wait(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                             output int lat, output logic [31:0] rd);
      int n;
      issue(we, a, d);
      n = 1;
      while (!resp_valid) begin
         @(negedge clk);
         n++;
         if (n > 300) begin
            check("resp_timeout", 1'b0, n, 300);
            finish_run();
         end
      end
      lat = n;
      rd  = resp_rdata;
   endtask

   task automatic clear_log();
      log_we.delete(); log_addr.delete(); log_wdata.delete();
   endtask

   task automatic check_init();
      int bad = 0;
      #1;
      for (int i = 0; i < 1024; i++) begin
         if (!(ram_tag_we && ram_addr == 10'(i) && ram_status_in == 3'b000 && ram_tag_in == '0
               && !ram_data_we && !req_ready)) bad++;
         @(negedge clk);
         #1;
      end
      check("init_sequence", bad == 0, bad, 0);
      check("init_ready_after", req_ready == 1'b1, req_ready, 1);
      bad = 0;
      for (int i = 0; i < 1024; i++) if (status_mem[i] != 3'b000) bad++;
      check("init_status_clear", bad == 0, bad, 0);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {req_ready, resp_valid, mem_req_valid, mem_req_we, ram_tag_we, ram_data_we} == 6'b0
            && resp_rdata == '0 && mem_req_addr == '0 && mem_wdata == '0,
            {resp_rdata, req_ready, resp_valid, mem_req_valid, mem_req_we, ram_tag_we, ram_data_we}, 0);
   endtask

   initial begin
      #800000;
      check("global_timeout", 1'b0, 0, 1);
      finish_run();
   end

   logic [9:0] idx_tab [4] = '{10'h123, 10'h000, 10'h3FF, 10'h055};

   initial begin
      int lat, guard;
      logic [31:0] rd;
      logic [AW-1:0] a;
      rstn = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      #3 rstn = 1'b0;
      fill_junk = 1'b1;
      @(negedge clk);
      fill_junk = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_outputs");
      rstn = 1'b1;
      check_init();

      // Cold load miss: fetch only, clean-valid status written.
      cfg_hold = 0; cfg_delay = 2; cfg_junk = 1'b0;
      clear_log();
      issue_wait(1'b0, 27'h0001230, 32'h0, lat, rd);
      check("d1_rdata", rd == 32'd1, rd, 1);
      check("d1_fetch", log_we.size() == 1 && log_we[0] == 1'b0 && log_addr[0] == 23'h00123,
            {log_we.size(), log_addr[0]}, {32'd1, 23'h00123});
      check("d1_status", status_mem[10'h123] == 3'b001 && tag_mem[10'h123] == '0,
            status_mem[10'h123], 3'b001);

      // Load hit.
      clear_log();
      issue_wait(1'b0, 27'h0001234, 32'h0, lat, rd);
      check("d2_latency", lat == 2, lat, 2);
      check("d2_rdata", rd == 32'd2, rd, 2);
      check("d2_no_mem", log_we.size() == 0, log_we.size(), 0);

      // Store hit.
      clear_log();
      issue_wait(1'b1, 27'h0001238, 32'hDEADBEEF, lat, rd);
      check("d3_latency", lat == 2, lat, 2);
      check("d3_no_mem", log_we.size() == 0, log_we.size(), 0);
      check("d3_line", data_mem[10'h123] == {32'd4, 32'hDEADBEEF, 32'd2, 32'd1},
            data_mem[10'h123], {32'd4, 32'hDEADBEEF, 32'd2, 32'd1});
      check("d3_status", status_mem[10'h123] == 3'b011, status_mem[10'h123], 3'b011);

      // Conflict miss on a dirty line, memory stalls 5 cycles per request.
      clear_log();
      cfg_hold = 5;
      issue_wait(1'b0, 27'h0005230, 32'h0, lat, rd);
      check("d4_count", log_we.size() == 2, log_we.size(), 2);
      check("d4_wb", log_we[0] == 1'b1 && log_addr[0] == 23'h00123 &&
            log_wdata[0] == {32'd4, 32'hDEADBEEF, 32'd2, 32'd1}, log_wdata[0],
            {32'd4, 32'hDEADBEEF, 32'd2, 32'd1});
      check("d4_fetch", log_we[1] == 1'b0 && log_addr[1] == 23'h00523, log_addr[1], 23'h00523);
      check("d4_rdata", rd == {23'h00523, 2'd0, 7'h5a}, rd, {23'h00523, 2'd0, 7'h5a});
      check("d4_status", status_mem[10'h123] == 3'b001 && tag_mem[10'h123] == 13'd1,
            {tag_mem[10'h123], status_mem[10'h123]}, {13'd1, 3'b001});

      // Clean victim is replaced without a write-back; stored word comes back from memory.
      clear_log();
      cfg_hold = 0;
      issue_wait(1'b0, 27'h0001238, 32'h0, lat, rd);
      check("d5_fetch_only", log_we.size() == 1 && log_we[0] == 1'b0 && log_addr[0] == 23'h00123,
            {log_we.size(), log_addr[0]}, {32'd1, 23'h00123});
      check("d5_rdata", rd == 32'hDEADBEEF, rd, 32'hDEADBEEF);

      // Randomised traffic over a few conflicting indices.
      cfg_hold = -1; cfg_delay = -1; cfg_junk = 1'b1;
      for (int k = 0; k < 300; k++) begin
         a = {13'($urandom_range(0, 3)), idx_tab[$urandom_range(0, 3)],
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         issue(1'($urandom_range(0, 1)), a, $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      guard = 0;
      while (exp_q.size() > 0 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      check("random_drain", exp_q.size() == 0, exp_q.size(), 0);

      // Reset while waiting for a fetched line.
      cfg_hold = 0; cfg_delay = 50; cfg_junk = 1'b0;
      clear_log();
      issue(1'b0, {13'h1FFF, 10'h200, 4'h0}, 32'h0);
      guard = 0;
      while (log_we.size() == 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("rst_fetch_seen", log_we.size() == 1 && log_addr[0] == {13'h1FFF, 10'h200},
            log_addr[0], {13'h1FFF, 10'h200});
      repeat (2) @(negedge clk);
      #2 rstn = 1'b0;
      #1 check_reset_outputs("reset_mid_outputs");
      exp_q.delete();
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      check_init();

      cfg_delay = 1;
      issue_wait(1'b0, {13'h1FFE, 10'h055, 4'h4}, 32'h0, lat, rd);
      check("post_reset_rdata", rd == {13'h1FFE, 10'h055, 2'd1, 7'h5a}, rd,
            {13'h1FFE, 10'h055, 2'd1, 7'h5a});
      repeat (3) @(negedge clk);
      check("final_drain", exp_q.size() == 0, exp_q.size(), 0);
      finish_run();
   end

endmodule
